// File: rtl/parity_pkg.sv
// Shared types and width helpers for the parity engine.
package parity_pkg;

  typedef enum logic {
    StIdle,
    StScan
  } state_e;

  // Width needed to hold a ones count in the range 0..data_w.
  function automatic int unsigned cnt_w(input int unsigned data_w);
    return $clog2(data_w + 1);
  endfunction

  // Chunk counter width; never narrower than one bit.
  function automatic int unsigned chunk_w(input int unsigned nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/parity_engine_if.sv
// Start/busy/done handshake and result bus of the parity engine.
interface parity_engine_if
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W = 8
);

  localparam int unsigned CntW = cnt_w(DATA_W);

  logic              start;
  logic [DATA_W-1:0] data_in;
  logic              check_mode;
  logic              check_bit;
  logic              busy;
  logic              done;
  logic [CntW-1:0]   ones_count;
  logic              even_parity;
  logic              odd_parity;
  logic              parity_err;

  modport master (
    output start, data_in, check_mode, check_bit,
    input  busy, done, ones_count, even_parity, odd_parity, parity_err
  );

  modport slave (
    input  start, data_in, check_mode, check_bit,
    output busy, done, ones_count, even_parity, odd_parity, parity_err
  );

endinterface

// File: rtl/popcount_chunk.sv
// Combinational ones counter for one scan chunk.
module popcount_chunk
  import parity_pkg::*;
#(
  parameter int unsigned W    = 1,
  parameter int unsigned OutW = cnt_w(W)
) (
  input  logic [W-1:0]    bits_i,
  output logic [OutW-1:0] count_o
);

  // Sum every bit of the chunk.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < int'(W); i++) begin
      count_o = count_o + OutW'(bits_i[i]);
    end
  end

endmodule

// File: rtl/parity_engine.sv
// Multi-cycle parity generator/checker: scans a latched word a chunk per cycle.
module parity_engine
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input logic             clk,
  input logic             rst,
  parity_engine_if.slave  bus
);

  localparam int unsigned NChunk = DATA_W / BITS_PER_CYCLE;
  localparam int unsigned CntW   = cnt_w(DATA_W);
  localparam int unsigned ChunkW = chunk_w(NChunk);
  localparam int unsigned PcW    = cnt_w(BITS_PER_CYCLE);

  if (DATA_W < 1 || BITS_PER_CYCLE < 1 || (DATA_W % BITS_PER_CYCLE) != 0) begin : gen_bad_param
    $error("parity_engine: BITS_PER_CYCLE must divide DATA_W (DATA_W >= 1)");
  end

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [ChunkW-1:0] chunk_q, chunk_d;
  logic [CntW-1:0]   acc_q, acc_d;
  logic              mode_q, mode_d;
  logic              chk_q, chk_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              even_q, even_d;
  logic              odd_q, odd_d;
  logic              err_q, err_d;

  logic [PcW-1:0]    chunk_ones;
  logic [CntW-1:0]   sum;
  logic              last_chunk;

  popcount_chunk #(
    .W    (BITS_PER_CYCLE),
    .OutW (PcW)
  ) u_popcount (
    .bits_i  (shift_q[BITS_PER_CYCLE-1:0]),
    .count_o (chunk_ones)
  );

  assign sum        = acc_q + CntW'(chunk_ones);
  assign last_chunk = (chunk_q == ChunkW'(NChunk - 1));

  // Next-state: accept in idle, accumulate one chunk per scan cycle, publish on the last.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    chunk_d = chunk_q;
    acc_d   = acc_q;
    mode_d  = mode_q;
    chk_d   = chk_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    count_d = count_q;
    even_d  = even_q;
    odd_d   = odd_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          shift_d = bus.data_in;
          mode_d  = bus.check_mode;
          chk_d   = bus.check_bit;
          acc_d   = '0;
          chunk_d = '0;
          busy_d  = 1'b1;
          even_d  = 1'b0;
          odd_d   = 1'b0;
          err_d   = 1'b0;
          state_d = StScan;
        end
      end
      StScan: begin
        acc_d   = sum;
        shift_d = shift_q >> BITS_PER_CYCLE;
        chunk_d = chunk_q + ChunkW'(1);
        if (last_chunk) begin
          chunk_d = '0;
          count_d = sum;
          even_d  = ~sum[0];
          odd_d   = sum[0];
          err_d   = mode_q & (sum[0] != chk_q);
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      chunk_q <= '0;
      acc_q   <= '0;
      mode_q  <= 1'b0;
      chk_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
      even_q  <= 1'b0;
      odd_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      chunk_q <= chunk_d;
      acc_q   <= acc_d;
      mode_q  <= mode_d;
      chk_q   <= chk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      count_q <= count_d;
      even_q  <= even_d;
      odd_q   <= odd_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.ones_count  = count_q;
  assign bus.even_parity = even_q;
  assign bus.odd_parity  = odd_q;
  assign bus.parity_err  = err_q;

endmodule

// File: doc/parity_engine.md
Name: parity_engine

Overview:
Parametrised successor to the 8-bit serial even/odd parity unit.
- Latches a DATA_W-bit word on start.
- Scans it BITS_PER_CYCLE bits per clock, accumulating a ones count.
- Reports ones_count, even/odd parity and, in check mode, a mismatch flag against a supplied parity bit.
- Sits behind a start/busy/done handshake as a reusable datapath+controller for bus-level parity generation and checking.

Parameters:
DATA_W, 8, width of the input word; must be at least 1.
BITS_PER_CYCLE, 1, bits consumed per scan cycle; must divide DATA_W exactly (elaboration error otherwise).

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
data_in  input  DATA_W  word to scan; sampled in the accepting cycle only.
check_mode  input  1  0 = generate, 1 = check; latched with data_in.
check_bit  input  1  expected odd-parity bit (1 = odd number of ones); latched with data_in.
busy  output  1  high while an operation is in flight.
done  output  1  one-cycle pulse when results update.
ones_count  output  CNT_W  number of ones; CNT_W = $clog2(DATA_W+1).
even_parity  output  1  1 when ones_count is even.
odd_parity  output  1  1 when ones_count is odd.
parity_err  output  1  check mode: 1 when odd_parity != latched check_bit; always 0 in generate mode.

Behaviour:
- Reset values: state IDLE, busy=0, done=0, ones_count=0, even_parity=0, odd_parity=0, parity_err=0, shift register 0, chunk counter 0.
- NCHUNK = DATA_W/BITS_PER_CYCLE. Chunk counter width is max(1, $clog2(NCHUNK)).
- FSM states: IDLE, SCAN.
- IDLE:
  - start=1 at edge E0 → shift_reg<=data_in, latch check_mode/check_bit.
  - Same edge: accumulator<=0, chunk<=0, busy<=1, clear even/odd/parity_err to 0, go to SCAN.
  - start=0 → stay; outputs hold.
- SCAN, each edge:
  - accumulator += popcount(shift_reg[BITS_PER_CYCLE-1:0]).
  - shift_reg >>= BITS_PER_CYCLE, chunk++.
- Last SCAN edge (chunk == NCHUNK-1), same edge:
  - ones_count <= final sum; even/odd set; parity_err computed.
  - busy<=0, done<=1, return to IDLE.
- done is high for exactly one cycle and is deasserted on the following edge.
- Latency: done and results are visible NCHUNK cycles after the accepting edge. busy is high for exactly NCHUNK cycles.
- start while busy=1 is ignored; it is not queued.
- start high in the done cycle is accepted, since the FSM is in IDLE. Back-to-back throughput is one word per NCHUNK+1 cycles.
- data_in and check inputs may change freely after acceptance without effect.
- Results hold from done until the next accepted start, which clears even/odd/parity_err. ones_count holds until the next done.
- Exactly one of even_parity/odd_parity is 1 after any completed operation. Both are 0 after reset or while busy.
- Arithmetic: the accumulator is CNT_W bits wide and cannot overflow (max value DATA_W). The chunk popcount is zero-extended to CNT_W.
- rst=1 in any state, including mid-SCAN: return to reset values on that edge, with no done pulse. A start in the same cycle as rst is dropped.
- Degenerate case NCHUNK=1: a single SCAN cycle; done comes 1 cycle after acceptance.

Decomposition:
- Package parity_pkg: state enum {IDLE, SCAN}; helper functions for CNT_W and chunk-counter width.
- Sub-module popcount_chunk: purely combinational; parameter W=BITS_PER_CYCLE; input W bits; output count of ones.
- parity_engine holds the FSM, shift register, chunk counter, accumulator and result registers.

Test Plan:
- DATA_W=8, BPC=1, data_in=0x91, generate mode → busy for 8 cycles; done 8 cycles after accept; ones_count=3, odd_parity=1, even_parity=0, parity_err=0.
- DATA_W=8, BPC=1, data_in=0x00, then back-to-back start in the done cycle with 0xFF → first: ones_count=0, even=1. Second accepted immediately; ones_count=8, even=1.
- DATA_W=16, BPC=4, data_in=0xFFFF → done exactly 4 cycles after accept; ones_count=16, even_parity=1.
- DATA_W=8, check_mode=1, data_in=0x07, check_bit=0 → parity_err=1. Repeat with check_bit=1 → parity_err=0.
- Pulse start again 3 cycles into a scan with different data_in → ignored; results match the first word; only one done pulse.
- Assert rst during cycle 4 of a scan → next cycle busy=0, done=0, all outputs 0. A later start completes normally.
